// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 command receiver (2-FF sync, deserializer, byte FIFO).
// Ports: clk, reset (sync, active-high), rx_serial (async line, idles
//   high), m_data/m_valid/m_ready (show-ahead valid/ready byte output),
//   frame_err/overflow (sticky, cleared by err_clr), fifo_count.
module uart_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16,
  localparam int unsigned AW = $clog2(FIFO_DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_serial,
  output logic [7:0]    m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          frame_err,
  output logic          overflow,
  input  logic          err_clr,
  output logic [CW-1:0] fifo_count
);

  localparam logic [15:0] BIT_LAST =
    16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST =
    16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT =
    CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  logic          sync1_q;
  logic          sync2_q;
  logic          rx_s;
  state_t        state_q;
  logic [15:0]   cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          push_q;
  logic          ferr_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ovf_q;
  logic          ovf_d;
  logic          full;
  logic          pop;
  logic          push;

  assign rx_s = sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_serial;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      // a new frame error below overrides the clear
      ferr_q <= ferr_q & ~err_clr;
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!rx_s) begin
              idx_q   <= '0;
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              push_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= BRK;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        BRK: begin
          // hold off until the break ends
          if (rx_s) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign full = (count_q == FULL_CNT);
  assign pop  = (count_q != '0) && m_ready;
  // a pop in the same cycle frees the slot
  assign push = push_q && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    ovf_d = (ovf_q & ~err_clr)
          | (push_q & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= shift_q;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign m_data     = mem_q[rd_q];
  assign m_valid    = (count_q != '0);
  assign fifo_count = count_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed bench for uart_cmd_rx with a byte scoreboard.
// Main DUT at 16 clks/bit, depth 4; second DUT at 868 clks/bit.
module tb_uart_cmd_rx;

  localparam int CPB  = 16;
  localparam int DEP  = 4;
  localparam int CW   = $clog2(DEP) + 1;
  localparam int CPB2 = 868;
  localparam int DEP2 = 16;
  localparam int CW2  = $clog2(DEP2) + 1;

  logic           clk;
  logic           reset;
  logic           rx;
  logic [7:0]     m_data;
  logic           m_valid;
  logic           m_ready;
  logic           frame_err;
  logic           overflow;
  logic           err_clr;
  logic [CW-1:0]  fifo_count;

  logic           rx2;
  logic [7:0]     m_data2;
  logic           m_valid2;
  logic           m_ready2;
  logic           frame_err2;
  logic           overflow2;
  logic [CW2-1:0] fifo_count2;

  int errors;
  int checks;
  logic [7:0] exp_q [$];

  uart_cmd_rx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_serial(rx),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .frame_err(frame_err),
    .overflow(overflow),
    .err_clr(err_clr),
    .fifo_count(fifo_count)
  );

  uart_cmd_rx #(
    .CLKS_PER_BIT(CPB2),
    .FIFO_DEPTH(DEP2)
  ) dut2 (
    .clk(clk),
    .reset(reset),
    .rx_serial(rx2),
    .m_data(m_data2),
    .m_valid(m_valid2),
    .m_ready(m_ready2),
    .frame_err(frame_err2),
    .overflow(overflow2),
    .err_clr(err_clr),
    .fifo_count(fifo_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=0x%0h exp=0x%0h",
             tag, got, exp);
    end
  endtask

  task automatic drv(input bit sel, input logic v);
    if (sel) rx2 = v;
    else     rx  = v;
  endtask

  // start + 8 data bits, then stop level; returns
  // just after the edge where the stop bit begins
  task automatic send_bits(input bit sel,
                           input logic [7:0] d,
                           input int cpb,
                           input logic stop);
    @(posedge clk);
    #1 drv(sel, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) @(posedge clk);
      #1 drv(sel, d[i]);
    end
    repeat (cpb) @(posedge clk);
    #1 drv(sel, stop);
  endtask

  task automatic send_frame(input bit sel,
                            input logic [7:0] d,
                            input int cpb);
    send_bits(sel, d, cpb, 1'b1);
    repeat (cpb - 1) @(posedge clk);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    int n;
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(m_valid), 32'd1);
    if (m_valid) begin
      chk({tag, "_sb"}, exp_q.size(), 32'd1 <= exp_q.size() ? exp_q.size() : 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      chk({tag, "_data"}, 32'(m_data), 32'(e));
      m_ready = 1'b1;
      @(posedge clk);
      #1 m_ready = 1'b0;
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    rx       = 1'b1;
    rx2      = 1'b1;
    m_ready  = 1'b0;
    m_ready2 = 1'b0;
    err_clr  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);

    // 1: single frame, exact push latency
    exp_q.push_back(8'hA5);
    send_bits(1'b0, 8'hA5, CPB, 1'b1);
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("t1_early", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("t1_rise", 32'(m_valid), 32'd1);
    chk("t1_count", 32'(fifo_count), 32'd1);
    chk("t1_ferr", 32'(frame_err), 32'd0);
    chk("t1_ovf", 32'(overflow), 32'd0);
    pop_check("t1_pop");
    @(negedge clk);
    chk("t1_empty", 32'(m_valid), 32'd0);
    chk("t1_cnt0", 32'(fifo_count), 32'd0);
    repeat (8) @(posedge clk);

    // 2: start-bit glitch
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    repeat (32) @(posedge clk);
    @(negedge clk);
    chk("t2_count", 32'(fifo_count), 32'd0);
    chk("t2_ferr", 32'(frame_err), 32'd0);

    // 3: framing error with break, then recovery
    send_bits(1'b0, 8'h3C, CPB, 1'b0);
    repeat (2 * CPB) @(posedge clk);
    #1 rx = 1'b1;
    repeat (CPB) @(posedge clk);
    @(negedge clk);
    chk("t3_ferr", 32'(frame_err), 32'd1);
    chk("t3_count", 32'(fifo_count), 32'd0);
    exp_q.push_back(8'h55);
    send_frame(1'b0, 8'h55, CPB);
    repeat (4) @(posedge clk);
    pop_check("t3_pop");
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    chk("t3_clr", 32'(frame_err), 32'd0);

    // 4: back-to-back overflow
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEP) exp_q.push_back(8'(i));
      send_frame(1'b0, 8'(i), CPB);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t4_count", 32'(fifo_count), 32'(DEP));
    chk("t4_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < DEP; i++) pop_check("t4_pop");
    @(negedge clk);
    chk("t4_drained", 32'(fifo_count), 32'd0);
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    chk("t4_clr", 32'(overflow), 32'd0);

    // 5: push into full FIFO with a pop on the same edge
    for (int i = 0; i < DEP; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      send_frame(1'b0, 8'h10 + 8'(i), CPB);
    end
    exp_q.push_back(8'h14);
    send_bits(1'b0, 8'h14, CPB, 1'b1);
    repeat (11) @(posedge clk);
    pop_check("t5_pop");
    @(negedge clk);
    chk("t5_count", 32'(fifo_count), 32'(DEP));
    chk("t5_ovf", 32'(overflow), 32'd0);
    repeat (4) @(posedge clk);
    for (int i = 0; i < DEP; i++) pop_check("t5_drain");
    @(negedge clk);
    chk("t5_sb", exp_q.size(), 32'd0);

    // 6: reset mid-frame, then a clean frame
    @(posedge clk);
    #1 rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (CPB) @(posedge clk);
      #1 rx = 1'b1;
    end
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_cnt", 32'(fifo_count), 32'd0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("t6_no_part", 32'(fifo_count), 32'd0);
    exp_q.push_back(8'h81);
    send_frame(1'b0, 8'h81, CPB);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t6_count", 32'(fifo_count), 32'd1);
    pop_check("t6_pop");
    chk("t6_ferr", 32'(frame_err), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);

    // 6b: full-rate divider sanity frame
    send_frame(1'b1, 8'h5A, CPB2);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!m_valid2 && n < 2000) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t6b_valid", 32'(m_valid2), 32'd1);
    chk("t6b_data", 32'(m_data2), 32'h5A);
    chk("t6b_count", 32'(fifo_count2), 32'd1);
    chk("t6b_ferr", 32'(frame_err2), 32'd0);
    chk("t6b_ovf", 32'(overflow2), 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
